// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV M-extension constants, operation enum and FSM state type
// used by the multiply/divide unit and its decoder.
package riscv_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Encoding equals funct3, so decode is a straight cast.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_decode.sv
// md_decode: recognises RV M-extension register ops and extracts the operation.
module md_decode
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_is_md_c,
  output md_op_t      o_op_c
);

  logic w_unused_c;

  always_comb begin
    o_is_md_c = (i_instr[6:0] == OP_REG) && (i_instr[31:25] == F7_MULDIV);
    o_op_c    = md_op_t'(i_instr[14:12]);
  end

  // Register specifiers are not needed by the unit.
  assign w_unused_c = ^{i_instr[24:15], i_instr[11:7]};

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: iterative RV M-extension multiply/divide unit, one bit per clock.
// Build option ALU_MD_DIV_EN: include the divider; without it divide ops finish flagged illegal.
module alu_md_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            is_md,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW  = 2 * XLEN;
  localparam int unsigned XW1 = XLEN + 1;
  localparam int unsigned CW  = $clog2(XLEN);
`ifdef ALU_MD_DIV_EN
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  md_state_t       r_state;
  md_op_t          r_op;
  logic [XLEN-1:0] r_a;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_lo;
  logic            r_special;
  logic            r_ill;
  logic [XLEN-1:0] r_spec_val;
  logic            r_busy;
  logic            r_done;
  logic            r_illegal;
  logic [XLEN-1:0] r_result;
`ifdef ALU_MD_DIV_EN
  logic            r_neg_hi;
`endif

  logic            w_is_md;
  md_op_t          w_op;
  logic            w_accept;
  logic            w_op_div;
  logic            w_sgn1;
  logic            w_sgn2;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XW1-1:0]  w_sum;
  logic [PW-1:0]   w_mul_next;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_final;
`ifdef ALU_MD_DIV_EN
  logic [XW1-1:0]  w_shift;
  logic [XW1-1:0]  w_diff;
  logic [PW-1:0]   w_div_next;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rmd;
`endif

  md_decode u_decode (
    .i_instr   (instr),
    .o_is_md_c (w_is_md),
    .o_op_c    (w_op)
  );

  // Launch qualification and operand magnitudes for the decoded op.
  always_comb begin
    w_accept = start && w_is_md && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    w_op_div = w_op[2];
    w_sgn1   = (w_op == MD_MULH) || (w_op == MD_MULHSU) || (w_op == MD_DIV) || (w_op == MD_REM);
    w_sgn2   = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
    w_neg1   = w_sgn1 && rs1_val[XLEN-1];
    w_neg2   = w_sgn2 && rs2_val[XLEN-1];
    w_mag1   = w_neg1 ? (XLEN'(0) - rs1_val) : rs1_val;
    w_mag2   = w_neg2 ? (XLEN'(0) - rs2_val) : rs2_val;
  end

  // Shift-add step: multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    w_sum      = {1'b0, r_acc[PW-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : XW1'(0));
    w_mul_next = {w_sum, r_acc[XLEN-1:1]};
  end

`ifdef ALU_MD_DIV_EN
  // Restoring step: remainder in the high half, dividend shifts out as quotient shifts in.
  always_comb begin
    w_shift    = {r_acc[PW-1:XLEN], r_acc[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_a};
    w_div_next = {(w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0]),
                  r_acc[XLEN-2:0], ~w_diff[XLEN]};
  end
`endif

  // Sign correction and result selection applied when leaving FIN.
  always_comb begin
    w_prod  = r_neg_lo ? (PW'(0) - r_acc) : r_acc;
    w_final = (r_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
`ifdef ALU_MD_DIV_EN
    w_quo   = r_neg_lo ? (XLEN'(0) - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_rmd   = r_neg_hi ? (XLEN'(0) - r_acc[PW-1:XLEN]) : r_acc[PW-1:XLEN];
    if (r_op[2]) begin
      w_final = r_op[1] ? w_rmd : w_quo;
    end
`endif
    if (r_special) begin
      w_final = r_spec_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= MD_MUL;
      r_a        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_lo   <= 1'b0;
      r_special  <= 1'b0;
      r_ill      <= 1'b0;
      r_spec_val <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_result   <= '0;
`ifdef ALU_MD_DIV_EN
      r_neg_hi   <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (flush) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_MUL: begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN - 1)) begin
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
            end
          end
`ifdef ALU_MD_DIV_EN
          ST_DIV: begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(XLEN - 1)) begin
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
            end
          end
`endif
          ST_FIN: begin
            r_done    <= 1'b1;
            r_illegal <= r_ill;
            r_result  <= w_final;
            r_state   <= ST_IDLE;
          end
          default: ;
        endcase

        // A start in FIN overrides the return to IDLE (back-to-back issue).
        if (w_accept) begin
          r_op       <= w_op;
          r_cnt      <= '0;
          r_special  <= 1'b0;
          r_ill      <= 1'b0;
          r_spec_val <= '0;
          if (!w_op_div) begin
            r_a      <= w_mag1;
            r_acc    <= {XLEN'(0), w_mag2};
            r_neg_lo <= w_neg1 ^ w_neg2;
            r_state  <= ST_MUL;
            r_busy   <= 1'b1;
          end else begin
`ifdef ALU_MD_DIV_EN
            r_neg_lo <= w_neg1 ^ w_neg2;
            r_neg_hi <= w_neg1;
            if (rs2_val == XLEN'(0)) begin
              r_special  <= 1'b1;
              r_spec_val <= w_op[1] ? rs1_val : {XLEN{1'b1}};
              r_state    <= ST_FIN;
            end else if (w_sgn1 && (rs1_val == XMIN) && (&rs2_val)) begin
              r_special  <= 1'b1;
              r_spec_val <= w_op[1] ? XLEN'(0) : rs1_val;
              r_state    <= ST_FIN;
            end else begin
              r_a     <= w_mag2;
              r_acc   <= {XLEN'(0), w_mag1};
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
            end
`else
            r_special <= 1'b1;
            r_ill     <= 1'b1;
            r_state   <= ST_FIN;
`endif
          end
        end
      end
    end
  end

  assign is_md   = w_is_md;
  assign busy    = r_busy;
  assign done    = r_done;
  assign illegal = r_illegal;
  assign result  = r_result;

endmodule
